// File: rtl/dendrite_arbiter_if.sv
// Handshake bundle between the synapse/incoming requesters and the dendrite arbiter.
interface dendrite_arbiter_if #(
  parameter int NUM_SYN = 4
);
  localparam int SEL_W = $clog2(NUM_SYN + 1);

  logic               enable;
  logic [NUM_SYN:0]   req_vld;
  logic               dend_rdy;
  logic [NUM_SYN:0]   req_rdy;
  logic [SEL_W-1:0]   grant_sel;
  logic               grant_vld;
  logic               dend_vld;

  modport master (
    output enable, req_vld, dend_rdy,
    input  req_rdy, grant_sel, grant_vld, dend_vld
  );

  modport slave (
    input  enable, req_vld, dend_rdy,
    output req_rdy, grant_sel, grant_vld, dend_vld
  );
endinterface

// File: rtl/dendrite_arbiter.sv
// Burst arbiter sharing the dendrite unit among NUM_SYN synapses plus the incoming port.
// Optional macro UCASPIAN_ARB_INCOMING_PRIO_EN: incoming port preferred, alternating with synapses.
module dendrite_arbiter #(
  parameter int NUM_SYN   = 4,
  parameter int MAX_BURST = 8
) (
  input  logic               clk,
  input  logic               reset,
  dendrite_arbiter_if.slave  arb
);
  localparam int NPORT = NUM_SYN + 1;
  localparam int SEL_W = $clog2(NPORT);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
`ifdef UCASPIAN_ARB_INCOMING_PRIO_EN
  localparam int RR_N = NUM_SYN;
`else
  localparam int RR_N = NPORT;
`endif

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   grant_sel_reg, grant_sel_next;
  logic               grant_vld_reg, grant_vld_next;
  logic [SEL_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]   burst_cnt_reg, burst_cnt_next;
  logic [SEL_W-1:0]   rr_winner, winner, ptr_after;
  logic               any_req, sel_vld, xfer, last_xfer;
`ifdef UCASPIAN_ARB_INCOMING_PRIO_EN
  logic               syn_turn_reg, syn_turn_next;
  logic               syn_pending;
`endif

  assign any_req   = |arb.req_vld;
  assign sel_vld   = arb.req_vld[grant_sel_reg];
  assign xfer      = grant_vld_reg & sel_vld & arb.dend_rdy;
  assign last_xfer = xfer && (burst_cnt_reg == CNT_W'(MAX_BURST - 1));
  assign ptr_after = (grant_sel_reg == SEL_W'(RR_N - 1)) ? '0 : grant_sel_reg + SEL_W'(1);

  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_rdy
      assign arb.req_rdy[gi] = arb.dend_rdy & grant_vld_reg & (grant_sel_reg == SEL_W'(gi));
    end
  endgenerate

  assign arb.grant_sel = grant_sel_reg;
  assign arb.grant_vld = grant_vld_reg;
  assign arb.dend_vld  = grant_vld_reg & sel_vld;

  // First asserted requester at or after rr_ptr, wrapping over the round-robin ring.
  always_comb begin : rr_search
    logic             found;
    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] idx;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    rr_winner = '0;
    for (int k = 0; k < RR_N; k++) begin
      sum = {1'b0, rr_ptr_reg} + (SEL_W + 1)'(k);
      if (sum >= (SEL_W + 1)'(RR_N)) sum = sum - (SEL_W + 1)'(RR_N);
      idx = sum[SEL_W-1:0];
      if (!found && arb.req_vld[idx]) begin
        found     = 1'b1;
        rr_winner = idx;
      end
    end
  end

`ifdef UCASPIAN_ARB_INCOMING_PRIO_EN
  assign syn_pending = |arb.req_vld[NUM_SYN-1:0];
  assign winner = (arb.req_vld[NUM_SYN] && !(syn_turn_reg && syn_pending)) ?
                  SEL_W'(NUM_SYN) : rr_winner;
`else
  assign winner = rr_winner;
`endif

  always_comb begin
    state_next     = state_reg;
    grant_sel_next = grant_sel_reg;
    grant_vld_next = grant_vld_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
`ifdef UCASPIAN_ARB_INCOMING_PRIO_EN
    syn_turn_next  = syn_turn_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (arb.enable && any_req) begin
          state_next     = GRANT;
          grant_sel_next = winner;
          grant_vld_next = 1'b1;
          burst_cnt_next = '0;
        end
      end
      GRANT: begin
        // dend_rdy low freezes the count and never forces a release.
        if (xfer) burst_cnt_next = burst_cnt_reg + CNT_W'(1);
        if (last_xfer || !sel_vld || !arb.enable) begin
          state_next     = IDLE;
          grant_vld_next = 1'b0;
`ifdef UCASPIAN_ARB_INCOMING_PRIO_EN
          if (grant_sel_reg == SEL_W'(NUM_SYN)) begin
            syn_turn_next = 1'b1;
          end else begin
            rr_ptr_next   = ptr_after;
            syn_turn_next = 1'b0;
          end
`else
          rr_ptr_next = ptr_after;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      grant_sel_reg <= '0;
      grant_vld_reg <= 1'b0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
`ifdef UCASPIAN_ARB_INCOMING_PRIO_EN
      syn_turn_reg  <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      grant_sel_reg <= grant_sel_next;
      grant_vld_reg <= grant_vld_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
`ifdef UCASPIAN_ARB_INCOMING_PRIO_EN
      syn_turn_reg  <= syn_turn_next;
`endif
    end
  end
endmodule

// File: tb/tb_dendrite_arbiter.sv
// Table-driven bench for dendrite_arbiter; expected outputs queued per driven cycle.
module tb_dendrite_arbiter;
  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  dendrite_arbiter_if #(.NUM_SYN(4)) arb ();

  dendrite_arbiter #(.NUM_SYN(4), .MAX_BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .arb   (arb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [4:0] req;
    logic       rdy;
    int         rep;
    logic       gv;
    int         gs;   // -1: grant_sel not checked
    logic       dv;
  } vec_t;

  typedef struct {
    logic       gv;
    int         gs;
    logic       dv;
    logic [4:0] rr;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

`ifdef UCASPIAN_ARB_INCOMING_PRIO_EN
  localparam int T2_FIRST  = 4;
  localparam int T2_SECOND = 0;
`else
  localparam int T2_FIRST  = 0;
  localparam int T2_SECOND = 4;
`endif

  task automatic add(input logic rst, input logic en, input logic [4:0] req, input logic rdy,
                     input int rep, input logic gv, input int gs, input logic dv);
    vec_t v;
    v.rst = rst; v.en = en; v.req = req; v.rdy = rdy;
    v.rep = rep; v.gv = gv; v.gs = gs; v.dv = dv;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    logic [4:0] one;
    // reset state
    add(0, 1, 5'b00000, 1, 1, 0, 0, 0);
    // round robin with full bursts: 1 then 2
    add(0, 1, 5'b00110, 1, 1, 0, -1, 0);
    add(0, 1, 5'b00110, 1, 8, 1, 1, 1);
    add(0, 1, 5'b00110, 1, 1, 0, -1, 0);
    add(0, 1, 5'b00110, 1, 8, 1, 2, 1);
    add(0, 1, 5'b00000, 1, 1, 0, -1, 0);
    // port 3 drops valid after 3 transfers
    add(0, 1, 5'b01000, 1, 1, 0, -1, 0);
    add(0, 1, 5'b01000, 1, 3, 1, 3, 1);
    add(0, 1, 5'b00000, 1, 1, 1, 3, 0);
    add(0, 1, 5'b00000, 1, 1, 0, -1, 0);
    // dendrite stall holds grant, count frozen, then exactly 8 transfers
    add(0, 1, 5'b00001, 1, 1, 0, -1, 0);
    add(0, 1, 5'b00001, 0, 20, 1, 0, 1);
    add(0, 1, 5'b00001, 1, 8, 1, 0, 1);
    add(0, 1, 5'b00001, 1, 1, 0, -1, 0);
    add(0, 1, 5'b00000, 1, 1, 1, 0, 0);
    add(0, 1, 5'b00000, 1, 1, 0, -1, 0);
    // reset mid-burst
    add(0, 1, 5'b00010, 1, 1, 0, -1, 0);
    add(0, 1, 5'b00010, 1, 4, 1, 1, 1);
    add(1, 1, 5'b00010, 1, 1, 1, 1, 1);
    add(0, 1, 5'b00000, 1, 1, 0, 0, 0);
    // incoming vs synapse 0 from rr_ptr=0
    add(0, 1, 5'b10001, 1, 1, 0, -1, 0);
    add(0, 1, 5'b10001, 1, 8, 1, T2_FIRST, 1);
    add(0, 1, 5'b10001, 1, 1, 0, -1, 0);
    add(0, 1, 5'b10001, 1, 8, 1, T2_SECOND, 1);
    add(0, 1, 5'b00000, 1, 1, 0, -1, 0);
    // enable drop mid-burst with a transfer in that cycle
    add(0, 1, 5'b00100, 1, 1, 0, -1, 0);
    add(0, 1, 5'b00100, 1, 3, 1, 2, 1);
    add(0, 0, 5'b00100, 1, 1, 1, 2, 1);
    add(0, 0, 5'b00100, 1, 3, 0, -1, 0);
    add(0, 1, 5'b00100, 1, 1, 0, -1, 0);
    add(0, 1, 5'b00100, 1, 8, 1, 2, 1);
    add(0, 1, 5'b00100, 1, 1, 0, -1, 0);

    reset        = 1'b1;
    arb.enable   = 1'b0;
    arb.req_vld  = '0;
    arb.dend_rdy = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        @(posedge clk);
        #1;
        reset        = tbl[i].rst;
        arb.enable   = tbl[i].en;
        arb.req_vld  = tbl[i].req;
        arb.dend_rdy = tbl[i].rdy;
        e.gv = tbl[i].gv;
        e.gs = tbl[i].gs;
        e.dv = tbl[i].dv;
        e.rr = '0;
        if (tbl[i].rdy && tbl[i].gv) begin
          one  = 5'b00001;
          e.rr = one << tbl[i].gs;
        end
        sb.push_back(e);

        @(negedge clk);
        e = sb.pop_front();
        $display("[TB] row %0d cyc %0d: en=%b req=%b rdy=%b -> gv=%b sel=%0d dv=%b rr=%b",
                 i, r, arb.enable, arb.req_vld, arb.dend_rdy,
                 arb.grant_vld, arb.grant_sel, arb.dend_vld, arb.req_rdy);
        check($sformatf("row%0d.%0d grant_vld", i, r), int'(arb.grant_vld), int'(e.gv));
        if (e.gs >= 0)
          check($sformatf("row%0d.%0d grant_sel", i, r), int'(arb.grant_sel), e.gs);
        check($sformatf("row%0d.%0d dend_vld", i, r), int'(arb.dend_vld), int'(e.dv));
        check($sformatf("row%0d.%0d req_rdy", i, r), int'(arb.req_rdy), int'(e.rr));
      end
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
